// File: rtl/mc_seq_ctrl.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer: decides when PC, IR and register file commit,
// drives the imem/dmem handshakes and halts on illegal opcodes or bus timeouts.
module mc_seq_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic             rf_we,
  output logic [2:0]       state,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int WC_W = $clog2(TIMEOUT);
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(TIMEOUT - 1);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_TRAP = 3'd5
  } state_t;

  state_t           state_reg, state_next;
  logic [WC_W-1:0]  wait_reg, wait_next;
  logic [1:0]       cause_reg, cause_next;
  logic [CNT_W-1:0] cnt_reg;

  logic is_load, is_store, is_br, is_legal;
  logic imem_req_c, dmem_req_c, dmem_we_c, ir_we_c, pc_we_c, rf_we_c;

  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);
  assign is_br    = (opcode == OP_BR);
  assign is_legal = (opcode == OP_R) || (opcode == OP_I) || is_load || is_store ||
                    is_br || (opcode == OP_JAL) || (opcode == OP_JALR) || (opcode == OP_LUI);

  always_comb begin
    state_next = state_reg;
    wait_next  = '0;
    cause_next = cause_reg;
    imem_req_c = 1'b0;
    dmem_req_c = 1'b0;
    dmem_we_c  = 1'b0;
    ir_we_c    = 1'b0;
    pc_we_c    = 1'b0;
    rf_we_c    = 1'b0;
    case (state_reg)
      S_IF: begin
        imem_req_c = 1'b1;
        if (imem_ack) begin
          ir_we_c    = 1'b1;
          state_next = S_ID;
        end else if (wait_reg == WAIT_LAST) begin
          state_next = S_TRAP;
          cause_next = 2'b10;
        end else begin
          wait_next = wait_reg + 1'b1;
        end
      end
      S_ID: begin
        if (!is_legal) begin
          state_next = S_TRAP;
          cause_next = 2'b01;
        end else begin
          state_next = S_EX;
        end
      end
      S_EX: begin
        // npc already holds the resolved branch target, so branches retire here.
        if (is_load || is_store) begin
          state_next = S_MEM;
        end else if (is_br) begin
          pc_we_c    = 1'b1;
          state_next = S_IF;
        end else begin
          state_next = S_WB;
        end
      end
      S_MEM: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = is_store;
        if (dmem_ack) begin
          if (is_store) begin
            pc_we_c    = 1'b1;
            state_next = S_IF;
          end else begin
            state_next = S_WB;
          end
        end else if (wait_reg == WAIT_LAST) begin
          state_next = S_TRAP;
          cause_next = 2'b10;
        end else begin
          wait_next = wait_reg + 1'b1;
        end
      end
      S_WB: begin
        rf_we_c    = 1'b1;
        pc_we_c    = 1'b1;
        state_next = S_IF;
      end
      S_TRAP: begin
        state_next = S_TRAP;
      end
      default: begin
        state_next = S_IF;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IF;
      wait_reg  <= '0;
      cause_reg <= 2'b00;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
      cause_reg <= cause_next;
      if (pc_we_c) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  // Strobes are masked while rst is high so an abandoned access never commits.
  assign imem_req   = imem_req_c & ~rst;
  assign dmem_req   = dmem_req_c & ~rst;
  assign dmem_we    = dmem_we_c  & ~rst;
  assign ir_we      = ir_we_c    & ~rst;
  assign pc_we      = pc_we_c    & ~rst;
  assign rf_we      = rf_we_c    & ~rst;
  assign state      = state_reg;
  assign trap       = (state_reg == S_TRAP) & ~rst;
  assign trap_cause = cause_reg;
  assign instr_cnt  = cnt_reg;

endmodule

// File: tb/tb_mc_seq_ctrl.sv
// Directed-vector bench for mc_seq_ctrl: each vector's expected outputs are queued by the
// stimulus process and checked by an independent monitor at the falling clock edge.
module tb_mc_seq_ctrl;

  logic        clk;
  logic        rst;
  logic [6:0]  opcode;
  logic        imem_ack;
  logic        dmem_ack;
  logic        imem_req;
  logic        dmem_req;
  logic        dmem_we;
  logic        ir_we;
  logic        pc_we;
  logic        rf_we;
  logic [2:0]  state;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [31:0] instr_cnt;

  mc_seq_ctrl #(.TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we),
    .pc_we(pc_we), .rf_we(rf_we), .state(state), .trap(trap), .trap_cause(trap_cause),
    .instr_cnt(instr_cnt)
  );

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_ILL = 7'b0001111;

  // {state, imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, trap, trap_cause}
  localparam logic [11:0] X_RST  = {3'd0, 7'b0000000, 2'b00};
  localparam logic [11:0] X_IF   = {3'd0, 7'b1000000, 2'b00};
  localparam logic [11:0] X_IFA  = {3'd0, 7'b1001000, 2'b00};
  localparam logic [11:0] X_ID   = {3'd1, 7'b0000000, 2'b00};
  localparam logic [11:0] X_EX   = {3'd2, 7'b0000000, 2'b00};
  localparam logic [11:0] X_EXB  = {3'd2, 7'b0000100, 2'b00};
  localparam logic [11:0] X_MLD  = {3'd3, 7'b0100000, 2'b00};
  localparam logic [11:0] X_MSTA = {3'd3, 7'b0110100, 2'b00};
  localparam logic [11:0] X_WB   = {3'd4, 7'b0000110, 2'b00};
  localparam logic [11:0] X_TI   = {3'd5, 7'b0000001, 2'b01};
  localparam logic [11:0] X_TT   = {3'd5, 7'b0000001, 2'b10};

  typedef struct packed {
    logic [11:0] outs;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  logic sample_req  = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin : monitor
    exp_t        e;
    logic [11:0] act;
    forever begin
      @(negedge clk or sample_req);
      while (sb.size() > 0) begin
        e   = sb.pop_front();
        act = {state, imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, trap, trap_cause};
        vectors++;
        if (act !== e.outs || instr_cnt !== e.cnt) begin
          miscompares++;
          $display("FAIL vec%0d: outs=%b cnt=%0d, expected outs=%b cnt=%0d",
                   vectors, act, instr_cnt, e.outs, e.cnt);
        end else begin
          $display("vec%0d ok: outs=%b cnt=%0d", vectors, act, instr_cnt);
        end
      end
    end
  end

  // Drive one cycle's inputs (called at posedge+1), queue its expectation, advance a cycle.
  task automatic step(input logic [6:0] op, input logic ia, input logic da,
                      input logic [11:0] x, input logic [31:0] c);
    opcode   = op;
    imem_ack = ia;
    dmem_ack = da;
    sb.push_back({x, c});
    @(posedge clk);
    #1;
  endtask

  // Assert rst mid-cycle, check outputs drop at once, hold a cycle with stray acks, release.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    sb.push_back({X_RST, 32'd0});
    sample_req = ~sample_req;
    @(posedge clk);
    #1;
    imem_ack = 1'b1;
    dmem_ack = 1'b1;
    sb.push_back({X_RST, 32'd0});
    @(posedge clk);
    #1;
    rst      = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst      = 1'b1;
    opcode   = OP_R;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    @(posedge clk);
    #1;
    imem_ack = 1'b1;
    sb.push_back({X_RST, 32'd0});
    @(posedge clk);
    #1;
    rst      = 1'b0;
    imem_ack = 1'b0;

    // R-type, zero-wait fetch
    step(OP_R, 1, 0, X_IFA, 0);
    step(OP_R, 0, 0, X_ID,  0);
    step(OP_R, 0, 0, X_EX,  0);
    step(OP_R, 0, 0, X_WB,  0);
    // LOAD with dmem_ack three cycles late
    step(OP_LD, 1, 0, X_IFA, 1);
    step(OP_LD, 0, 0, X_ID,  1);
    step(OP_LD, 0, 0, X_EX,  1);
    step(OP_LD, 0, 0, X_MLD, 1);
    step(OP_LD, 0, 0, X_MLD, 1);
    step(OP_LD, 0, 0, X_MLD, 1);
    step(OP_LD, 0, 1, X_MLD, 1);
    step(OP_LD, 0, 0, X_WB,  1);
    // STORE then BR, stray imem_ack in the branch's EX
    step(OP_ST, 1, 0, X_IFA,  2);
    step(OP_ST, 0, 0, X_ID,   2);
    step(OP_ST, 0, 0, X_EX,   2);
    step(OP_ST, 0, 1, X_MSTA, 2);
    step(OP_BR, 1, 0, X_IFA,  3);
    step(OP_BR, 0, 0, X_ID,   3);
    step(OP_BR, 1, 0, X_EXB,  3);
    // fetch acked on the 16th IF cycle (first one carries a stray dmem_ack)
    step(OP_JAL, 0, 1, X_IF, 4);
    for (int i = 0; i < 14; i++) step(OP_JAL, 0, 0, X_IF, 4);
    step(OP_JAL, 1, 0, X_IFA, 4);
    step(OP_JAL, 0, 0, X_ID,  4);
    step(OP_JAL, 0, 0, X_EX,  4);
    step(OP_JAL, 0, 0, X_WB,  4);
    // LOAD interrupted by reset while dmem_req is high
    step(OP_LD, 1, 0, X_IFA, 5);
    step(OP_LD, 0, 0, X_ID,  5);
    step(OP_LD, 0, 0, X_EX,  5);
    step(OP_LD, 0, 0, X_MLD, 5);
    async_reset();
    // fetch never acked: trap after exactly 16 IF cycles, then absorbing
    for (int i = 0; i < 16; i++) step(OP_R, 0, 0, X_IF, 0);
    step(OP_R, 1, 1, X_TT, 0);
    step(OP_R, 1, 1, X_TT, 0);
    async_reset();
    // illegal opcode
    step(OP_ILL, 1, 0, X_IFA, 0);
    step(OP_ILL, 0, 0, X_ID,  0);
    step(OP_ILL, 1, 1, X_TI,  0);
    step(OP_ILL, 1, 0, X_TI,  0);
    step(OP_R,   1, 1, X_TI,  0);

    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d vectors unchecked, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
